// File: rtl/core_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package core_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_e;

  // Stall/flush controls for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_stall;
    logic stall_ifid;
    logic flush_ifid;
    logic stall_idex;
    logic flush_idex;
    logic stall_exmem;
    logic flush_exmem;
    logic flush_memwb;
  } hz_ctrl_t;

  // Load in E writes a register that the instruction in D reads.
  function automatic logic lu_hazard(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 use_rs1,
    input logic                 use_rs2
  );
    return mem_read && (rd != REG_X0) &&
           ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and branch-flush event counters; clear wins over increment.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc_i) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_events_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush generation with wait-state FSM, watchdog and perf counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs1_d,
  input  logic [REG_IDX_W-1:0] rs2_d,
  input  logic                 use_rs1_d,
  input  logic                 use_rs2_d,
  input  logic [REG_IDX_W-1:0] rd_e,
  input  logic                 mem_read_e,
  input  logic                 branch_taken_e,
  input  logic                 mdu_start_e,
  input  logic                 mdu_done,
  input  logic                 dmem_req_m,
  input  logic                 dmem_ack,
  input  logic                 clr_cnt,
  output logic                 pc_stall,
  output logic                 stall_ifid,
  output logic                 flush_ifid,
  output logic                 stall_idex,
  output logic                 flush_idex,
  output logic                 stall_exmem,
  output logic                 flush_exmem,
  output logic                 flush_memwb,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic                 err_timeout
);

  logic      memw_c, mduw_c, lu_c, br_flush_c;
  hz_ctrl_t  ctrl_c;
  hz_state_e state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic      err_q, err_d;

  assign memw_c = dmem_req_m & ~dmem_ack;
  assign mduw_c = mdu_start_e & ~mdu_done;
  assign lu_c   = lu_hazard(mem_read_e, rd_e, rs1_d, rs2_d, use_rs1_d, use_rs2_d);

  // Single prioritised action per cycle; reset forces everything quiet.
  always_comb begin
    ctrl_c = '0;
    if (reset) begin
      if (memw_c) begin
        ctrl_c.pc_stall    = 1'b1;
        ctrl_c.stall_ifid  = 1'b1;
        ctrl_c.stall_idex  = 1'b1;
        ctrl_c.stall_exmem = 1'b1;
        ctrl_c.flush_memwb = 1'b1;
      end else if (mduw_c) begin
        ctrl_c.pc_stall    = 1'b1;
        ctrl_c.stall_ifid  = 1'b1;
        ctrl_c.stall_idex  = 1'b1;
        ctrl_c.flush_exmem = 1'b1;
      end else if (branch_taken_e) begin
        ctrl_c.flush_ifid  = 1'b1;
        ctrl_c.flush_idex  = 1'b1;
      end else if (lu_c) begin
        ctrl_c.pc_stall    = 1'b1;
        ctrl_c.stall_ifid  = 1'b1;
        ctrl_c.flush_idex  = 1'b1;
      end
    end
  end

  assign br_flush_c = reset & ~memw_c & ~mduw_c & branch_taken_e;

  assign pc_stall    = ctrl_c.pc_stall;
  assign stall_ifid  = ctrl_c.stall_ifid;
  assign flush_ifid  = ctrl_c.flush_ifid;
  assign stall_idex  = ctrl_c.stall_idex;
  assign flush_idex  = ctrl_c.flush_idex;
  assign stall_exmem = ctrl_c.stall_exmem;
  assign flush_exmem = ctrl_c.flush_exmem;
  assign flush_memwb = ctrl_c.flush_memwb;

  // Wait-state tracking; feeds the watchdog only, never the outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (memw_c)      state_d = MEM_WAIT;
        else if (mduw_c) state_d = MDU_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ack) state_d = RUN;
      end
      MDU_WAIT: begin
        if (memw_c)       state_d = MEM_WAIT;
        else if (!mduw_c) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Wait counter restarts on any state change and saturates at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q != RUN) && (wait_cnt_q != TO_W'(TIMEOUT))) begin
      wait_cnt_d = wait_cnt_q + TO_W'(1);
    end
    err_d = err_q | (wait_cnt_d == TO_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;

  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (clk),
    .rst_n          (reset),
    .clr_i          (clr_cnt),
    .stall_inc_i    (ctrl_c.pc_stall),
    .flush_inc_i    (br_flush_c),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );

endmodule
